// File: rtl/ball_sprite_gen.sv
// Ball sprite pixel source for the VGA driver.
// Draws a square ball over a flat background, moves it once per frame
// and reports position, frame ticks and wall bounces to game logic.
module ball_sprite_gen #(
   parameter int          H_ACTIVE   = 640,
   parameter int          V_ACTIVE   = 480,
   parameter int          SIZE       = 16,
   parameter int          STEP       = 2,
   parameter int          X0         = 100,
   parameter int          Y0         = 50,
   parameter logic [15:0] BALL_COLOR = 16'hFFE0,
   parameter logic [15:0] BG_COLOR   = 16'h001F
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic [9:0]  column_i,
   input  logic [8:0]  row_i,
   output logic [15:0] rgb_o,
   output logic [9:0]  ball_x_o,
   output logic [8:0]  ball_y_o,
   output logic        frame_o,
   output logic        bounce_o,
   output logic [7:0]  bounce_count_o
);

   typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_t;

   // Widened copies so edge sums never wrap near the screen boundary.
   logic [10:0] col_ext;
   logic [9:0]  row_ext;
   logic [10:0] ball_x_end;
   logic [9:0]  ball_y_end;
   logic        blanking;
   logic        in_ball;
   logic [15:0] pixel_next;

   // Frame tick detection: rising edge of the last-visible-pixel match.
   logic match;
   logic match_q;
   logic tick;

   // Per-axis motion state and next-state results.
   dir_t        dir_x;
   dir_t        dir_y;
   dir_t        dir_x_next;
   dir_t        dir_y_next;
   logic [10:0] x_plus;
   logic [9:0]  y_plus;
   logic [9:0]  x_next;
   logic [8:0]  y_next;
   logic        hit_x;
   logic        hit_y;

   // Pixel classification: blanking, inside the ball, or background.
   always_comb begin
      col_ext    = {1'b0, column_i};
      row_ext    = {1'b0, row_i};
      ball_x_end = {1'b0, ball_x_o} + 11'(SIZE);
      ball_y_end = {1'b0, ball_y_o} + 10'(SIZE);
      blanking   = (col_ext >= 11'(H_ACTIVE)) || (row_ext >= 10'(V_ACTIVE));
      in_ball    = (column_i >= ball_x_o) && (col_ext < ball_x_end) &&
                   (row_i >= ball_y_o) && (row_ext < ball_y_end);
      pixel_next = BG_COLOR;
      if (blanking)
         pixel_next = 16'h0000;
      else if (in_ball)
         pixel_next = BALL_COLOR;
   end

   // The last visible pixel marks end of frame; only its first cycle counts.
   always_comb begin
      match = (column_i == 10'(H_ACTIVE - 1)) && (row_i == 9'(V_ACTIVE - 1));
      tick  = match && !match_q;
   end

   // Next position and direction for both axes, clamped at the walls.
   always_comb begin
      x_plus     = {1'b0, ball_x_o} + 11'(STEP);
      y_plus     = {1'b0, ball_y_o} + 10'(STEP);
      x_next     = ball_x_o;
      y_next     = ball_y_o;
      dir_x_next = dir_x;
      dir_y_next = dir_y;
      hit_x      = 1'b0;
      hit_y      = 1'b0;

      if (dir_x == DIR_POS) begin
         if (x_plus >= 11'(H_ACTIVE - SIZE)) begin
            x_next     = 10'(H_ACTIVE - SIZE);
            dir_x_next = DIR_NEG;
            hit_x      = 1'b1;
         end else begin
            x_next = x_plus[9:0];
         end
      end else begin
         if (ball_x_o <= 10'(STEP)) begin
            x_next     = 10'd0;
            dir_x_next = DIR_POS;
            hit_x      = 1'b1;
         end else begin
            x_next = ball_x_o - 10'(STEP);
         end
      end

      if (dir_y == DIR_POS) begin
         if (y_plus >= 10'(V_ACTIVE - SIZE)) begin
            y_next     = 9'(V_ACTIVE - SIZE);
            dir_y_next = DIR_NEG;
            hit_y      = 1'b1;
         end else begin
            y_next = y_plus[8:0];
         end
      end else begin
         if (ball_y_o <= 9'(STEP)) begin
            y_next     = 9'd0;
            dir_y_next = DIR_POS;
            hit_y      = 1'b1;
         end else begin
            y_next = ball_y_o - 9'(STEP);
         end
      end
   end

   // Registered pixel output, one cycle behind the incoming coordinates.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)
         rgb_o <= 16'h0000;
      else
         rgb_o <= pixel_next;
   end

   // Frame tick registration; frame_o pulses regardless of enable.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         match_q <= 1'b0;
         frame_o <= 1'b0;
      end else begin
         match_q <= match;
         frame_o <= tick;
      end
   end

   // Motion FSM: position, direction and bounce reporting, updated on the tick.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         ball_x_o       <= 10'(X0);
         ball_y_o       <= 9'(Y0);
         dir_x          <= DIR_POS;
         dir_y          <= DIR_POS;
         bounce_o       <= 1'b0;
         bounce_count_o <= 8'd0;
      end else begin
         bounce_o <= 1'b0;
         if (tick && enable_i) begin
            ball_x_o <= x_next;
            ball_y_o <= y_next;
            dir_x    <= dir_x_next;
            dir_y    <= dir_y_next;
            if (hit_x || hit_y) begin
               bounce_o       <= 1'b1;
               bounce_count_o <= bounce_count_o + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ball_sprite_gen.sv
// Scoreboard bench for ball_sprite_gen: three instances (default start,
// near the right wall, in the bottom-right corner) share one stimulus stream.
module tb_ball_sprite_gen;

   localparam logic [15:0] BALL = 16'hFFE0;
   localparam logic [15:0] BG   = 16'h001F;

   typedef struct packed {
      logic [9:0] x;
      logic [8:0] y;
      logic       bounce;
      logic [7:0] count;
   } frameExp_t;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        enable_i;
   logic [9:0]  column_i;
   logic [8:0]  row_i;

   logic [15:0] rgbD, rgbW, rgbC;
   logic [9:0]  xD, xW, xC;
   logic [8:0]  yD, yW, yC;
   logic        frameD, frameW, frameC;
   logic        bounceD, bounceW, bounceC;
   logic [7:0]  countD, countW, countC;

   int vectors = 0;
   int miscompares = 0;

   logic        pixReq = 1'b0;
   logic        pixStage = 1'b0;
   logic [15:0] pixQ[$];
   frameExp_t   qD[$];
   frameExp_t   qW[$];
   frameExp_t   qC[$];

   ball_sprite_gen dut (
      .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
      .column_i(column_i), .row_i(row_i), .rgb_o(rgbD),
      .ball_x_o(xD), .ball_y_o(yD), .frame_o(frameD),
      .bounce_o(bounceD), .bounce_count_o(countD)
   );

   ball_sprite_gen #(.X0(622)) dutWall (
      .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
      .column_i(column_i), .row_i(row_i), .rgb_o(rgbW),
      .ball_x_o(xW), .ball_y_o(yW), .frame_o(frameW),
      .bounce_o(bounceW), .bounce_count_o(countW)
   );

   ball_sprite_gen #(.X0(624), .Y0(464)) dutCorner (
      .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
      .column_i(column_i), .row_i(row_i), .rgb_o(rgbC),
      .ball_x_o(xC), .ball_y_o(yC), .frame_o(frameC),
      .bounce_o(bounceC), .bounce_count_o(countC)
   );

   // 100 MHz pixel clock.
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkFrame(input string name, input logic [9:0] x, input logic [8:0] y,
                             input logic b, input logic [7:0] c, input frameExp_t e);
      checkOutput({name, ".x"}, int'(x), int'(e.x));
      checkOutput({name, ".y"}, int'(y), int'(e.y));
      checkOutput({name, ".bounce"}, int'(b), int'(e.bounce));
      checkOutput({name, ".count"}, int'(c), int'(e.count));
   endtask

   task automatic applyStimulus(input int col, input int row, input logic checkPix,
                                input logic [15:0] expRgb);
      @(posedge clk_i);
      #2;
      column_i = 10'(col);
      row_i    = 9'(row);
      pixReq   = checkPix;
      if (checkPix)
         pixQ.push_back(expRgb);
   endtask

   // One frame tick: hold the last visible pixel, then move away so the next tick can fire.
   task automatic doTick(input int holdCycles, input frameExp_t eD, input frameExp_t eW,
                         input frameExp_t eC);
      qD.push_back(eD);
      qW.push_back(eW);
      qC.push_back(eC);
      for (int i = 0; i < holdCycles; i++)
         applyStimulus(639, 479, 1'b0, 16'h0000);
      applyStimulus(0, 0, 1'b0, 16'h0000);
      applyStimulus(1, 0, 1'b0, 16'h0000);
   endtask

   // Delay the pixel-check request to line up with the registered rgb_o.
   always @(posedge clk_i) pixStage <= pixReq;

   // Pixel monitor: compare rgb_o against the next queued expectation.
   always @(negedge clk_i) begin
      if (pixStage) begin
         if (pixQ.size() == 0)
            checkOutput("pixUnexpected", 1, 0);
         else
            checkOutput("rgb", int'(rgbD), int'(pixQ.pop_front()));
      end
   end

   // Frame monitors: each frame_o pulse consumes one expected ball state.
   always @(negedge clk_i) begin
      if (reset_i === 1'b1) begin
         if (bounceD && !frameD) checkOutput("bounceAloneD", 1, 0);
         if (bounceW && !frameW) checkOutput("bounceAloneW", 1, 0);
         if (bounceC && !frameC) checkOutput("bounceAloneC", 1, 0);
         if (frameD) begin
            if (qD.size() == 0) checkOutput("frameUnexpectedD", 1, 0);
            else checkFrame("frameD", xD, yD, bounceD, countD, qD.pop_front());
         end
         if (frameW) begin
            if (qW.size() == 0) checkOutput("frameUnexpectedW", 1, 0);
            else checkFrame("frameW", xW, yW, bounceW, countW, qW.pop_front());
         end
         if (frameC) begin
            if (qC.size() == 0) checkOutput("frameUnexpectedC", 1, 0);
            else checkFrame("frameC", xC, yC, bounceC, countC, qC.pop_front());
         end
      end
   end

   initial begin
      reset_i  = 1'b0;
      enable_i = 1'b0;
      column_i = 10'd0;
      row_i    = 9'd0;
      repeat (3) @(posedge clk_i);
      #2 reset_i = 1'b1;

      // Mid-line asynchronous reset, checked before any further clock edge.
      applyStimulus(10, 10, 1'b1, BG);
      applyStimulus(20, 10, 1'b0, 16'h0000);
      @(posedge clk_i);
      #2 reset_i = 1'b0;
      #1;
      checkOutput("resetRgb", int'(rgbD), 0);
      checkOutput("resetX", int'(xD), 100);
      checkOutput("resetY", int'(yD), 50);
      checkOutput("resetCount", int'(countD), 0);
      checkOutput("resetFrame", int'(frameD), 0);
      checkOutput("resetBounce", int'(bounceD), 0);
      checkOutput("resetWallX", int'(xW), 622);
      checkOutput("resetCornerY", int'(yC), 464);
      #4 reset_i = 1'b1;

      // Pixel map around the ball at (100,50).
      applyStimulus(100, 50, 1'b1, BALL);
      applyStimulus(115, 65, 1'b1, BALL);
      applyStimulus(116, 50, 1'b1, BG);
      applyStimulus(99, 50, 1'b1, BG);
      applyStimulus(100, 66, 1'b1, BG);
      applyStimulus(100, 49, 1'b1, BG);
      applyStimulus(640, 10, 1'b1, 16'h0000);
      applyStimulus(0, 480, 1'b1, 16'h0000);
      applyStimulus(639, 478, 1'b1, BG);
      applyStimulus(0, 0, 1'b0, 16'h0000);

      // Motion: first tick from a 4-cycle hold; wall and corner bounce.
      enable_i = 1'b1;
      doTick(4, frameExp_t'{10'd102, 9'd52, 1'b0, 8'd0},
                frameExp_t'{10'd624, 9'd52, 1'b1, 8'd1},
                frameExp_t'{10'd624, 9'd464, 1'b1, 8'd1});
      doTick(1, frameExp_t'{10'd104, 9'd54, 1'b0, 8'd0},
                frameExp_t'{10'd622, 9'd54, 1'b0, 8'd1},
                frameExp_t'{10'd622, 9'd462, 1'b0, 8'd1});

      // Ball now at (104,54): redraw check after the move.
      applyStimulus(104, 54, 1'b1, BALL);
      applyStimulus(103, 54, 1'b1, BG);

      // Frozen: ticks still pulse frame_o, nothing moves.
      enable_i = 1'b0;
      for (int t = 0; t < 3; t++)
         doTick(2, frameExp_t'{10'd104, 9'd54, 1'b0, 8'd0},
                   frameExp_t'{10'd622, 9'd54, 1'b0, 8'd1},
                   frameExp_t'{10'd622, 9'd462, 1'b0, 8'd1});

      // Resume motion from the frozen position.
      enable_i = 1'b1;
      doTick(1, frameExp_t'{10'd106, 9'd56, 1'b0, 8'd0},
                frameExp_t'{10'd620, 9'd56, 1'b0, 8'd1},
                frameExp_t'{10'd620, 9'd460, 1'b0, 8'd1});

      repeat (4) @(posedge clk_i);
      #3;
      checkOutput("pixPending", pixQ.size(), 0);
      checkOutput("framePendingD", qD.size(), 0);
      checkOutput("framePendingW", qW.size(), 0);
      checkOutput("framePendingC", qC.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
